// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sdram_pkg
// Brief    : Shared widths, BIST state encoding and the address-derived pattern.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    localparam int c_ADDR_W = 24;
    localparam int c_DATA_W = 16;
    localparam int c_ERR_W  = 16;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR_REQ  = 3'd1;
    localparam logic [2:0] c_ST_RD_REQ  = 3'd2;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    // Folding the upper address byte in makes every 64K bank produce a distinct pattern.
    function automatic logic [c_DATA_W-1:0] pat(input logic [c_ADDR_W-1:0] a,
                                                 input logic [c_DATA_W-1:0] seed);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_bist_cmp.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bist_cmp
// Brief    : Read-back comparator with saturating error count and first-error capture.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_bist_cmp
    import sdram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int ERR_W  = c_ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_expected,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic [DATA_W-1:0] o_first_err_data
);

    logic [ERR_W-1:0]  r_err_count;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic [DATA_W-1:0] r_first_err_data;
    logic              w_mismatch;

    assign w_mismatch = i_valid && (i_data != i_expected);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
        end else if (w_mismatch) begin
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + 1'b1;
            end
            // A zero count doubles as the "nothing captured yet" flag.
            if (r_err_count == '0) begin
                r_first_err_addr <= i_addr;
                r_first_err_data <= i_data;
            end
        end
    end

    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;
    assign o_first_err_data = r_first_err_data;

endmodule
`default_nettype wire

// File: rtl/sdram_bist.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bist
// Brief    : SDRAM request-port BIST: writes pat(addr) over a range, reads back, compares.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_bist
    import sdram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic              sdram_req,
    input  logic              sdram_ack,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rh_wl,
    output logic [DATA_W-1:0] sdram_data_w,
    input  logic [DATA_W-1:0] sdram_data_r,
    input  logic              sdram_data_r_en
);

    localparam logic [TMO_W-1:0] c_TMO_MAX = '1;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_seed;
    logic [DATA_W-1:0] r_data_w;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_req;
    logic              r_rh_wl;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;

    logic              w_start;
    logic              w_ack;
    logic              w_rd_data;
    logic              w_last;
    logic              w_tmo_hit;
    logic [ADDR_W-1:0] w_cnt_inc;
    logic [DATA_W-1:0] w_pat_cur;
    logic [15:0]       w_err_count;

    assign w_start   = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_ack     = r_req && sdram_ack;
    assign w_rd_data = (r_state == c_ST_RD_WAIT) && sdram_data_r_en;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc == r_len);
    assign w_tmo_hit = (r_tmo == c_TMO_MAX);
    assign w_pat_cur = pat(r_cur, r_seed);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_cur     <= '0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_seed    <= '0;
            r_data_w  <= '0;
            r_tmo     <= '0;
            r_req     <= 1'b0;
            r_rh_wl   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_start) begin
                        r_base    <= base_addr;
                        r_len     <= length;
                        r_seed    <= seed;
                        r_cur     <= base_addr;
                        r_cnt     <= '0;
                        r_tmo     <= '0;
                        r_timeout <= 1'b0;
                        if (length == '0) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= c_ST_WR_REQ;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                // Request is (re)issued one cycle after the previous ack, giving the low gap.
                c_ST_WR_REQ: begin
                    if (w_ack) begin
                        r_req <= 1'b0;
                        r_tmo <= '0;
                        if (w_last) begin
                            r_state <= c_ST_RD_REQ;
                            r_cnt   <= '0;
                            r_cur   <= r_base;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            r_cur <= r_cur + 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_state   <= c_ST_DONE;
                        r_req     <= 1'b0;
                        r_tmo     <= '0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (!r_req) begin
                            r_req    <= 1'b1;
                            r_addr   <= r_cur;
                            r_rh_wl  <= 1'b0;
                            r_data_w <= w_pat_cur;
                        end
                    end
                end
                c_ST_RD_REQ: begin
                    if (w_ack) begin
                        r_state <= c_ST_RD_WAIT;
                        r_req   <= 1'b0;
                        r_tmo   <= '0;
                    end else if (w_tmo_hit) begin
                        r_state   <= c_ST_DONE;
                        r_req     <= 1'b0;
                        r_tmo     <= '0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (!r_req) begin
                            r_req   <= 1'b1;
                            r_addr  <= r_cur;
                            r_rh_wl <= 1'b1;
                        end
                    end
                end
                c_ST_RD_WAIT: begin
                    if (w_rd_data) begin
                        r_tmo <= '0;
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= c_ST_RD_REQ;
                            r_cnt   <= w_cnt_inc;
                            r_cur   <= r_cur + 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_state   <= c_ST_DONE;
                        r_tmo     <= '0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    sdram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ERR_W  (16)
    ) u_cmp (
        .clk              (clk),
        .rst              (reset),
        .i_clear          (w_start),
        .i_valid          (w_rd_data),
        .i_addr           (r_cur),
        .i_data           (sdram_data_r),
        .i_expected       (w_pat_cur),
        .o_err_count      (w_err_count),
        .o_first_err_addr (first_err_addr),
        .o_first_err_data (first_err_data)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_done && (w_err_count == '0) && !r_timeout;
    assign timeout      = r_timeout;
    assign err_count    = w_err_count;
    assign sdram_req    = r_req;
    assign sdram_addr   = r_addr;
    assign sdram_rh_wl  = r_rh_wl;
    assign sdram_data_w = r_data_w;

endmodule
`default_nettype wire
